// File: rtl/aemb_mdu_pkg.sv
// Shared definitions for the AEMB multiply/divide unit: op codes, FSM states
// and the counter-width helper used by the divider core.
package aemb_mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHU  = 3'd2;
   localparam logic [2:0] OP_MULHSU = 3'd3;
   localparam logic [2:0] OP_IDIV   = 3'd4;
   localparam logic [2:0] OP_IDIVU  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } mduState_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result = result + 1;
      return result;
   endfunction

endpackage

// File: rtl/aemb_mdu_div.sv
// Restoring divider core: one quotient bit per clock, DW iterations after start.
// Operands are unsigned magnitudes; sign handling lives in the parent.
module aemb_mdu_div
   import aemb_mdu_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          gclk,
   input  logic          grst,
   input  logic          abort,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          running,
   output logic          last,
   output logic [DW-1:0] quotient
);

   localparam int CW = clog2(DW);

   logic [CW-1:0] count;
   logic [DW-1:0] remReg;
   logic [DW-1:0] quoReg;
   logic [DW-1:0] divReg;
   logic [DW:0]   trial;

   // The dividend shifts out of quoReg into the remainder while quotient bits shift in.
   assign trial    = {remReg, quoReg[DW-1]} - {1'b0, divReg};
   assign last     = running && (count == CW'(DW - 1));
   assign quotient = quoReg;

   always_ff @(posedge gclk) begin
      if (grst || abort) begin
         running <= 1'b0;
         count   <= '0;
         remReg  <= '0;
         quoReg  <= '0;
         divReg  <= '0;
      end else if (start) begin
         running <= 1'b1;
         count   <= '0;
         remReg  <= '0;
         quoReg  <= dividend;
         divReg  <= divisor;
      end else if (running) begin
         if (!trial[DW]) begin
            remReg <= trial[DW-1:0];
            quoReg <= {quoReg[DW-2:0], 1'b1};
         end else begin
            remReg <= {remReg[DW-2:0], quoReg[DW-1]};
            quoReg <= {quoReg[DW-2:0], 1'b0};
         end
         count <= count + CW'(1);
         if (last) running <= 1'b0;
      end
   end

endmodule

// File: rtl/aemb_mdu.sv
// Multi-cycle multiply/divide unit for the AEMB execute stage.
// Define AEMB_MDU_DIV_EN to build the IDIV/IDIVU divider path.
module aemb_mdu
   import aemb_mdu_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          gclk,
   input  logic          grst,
   input  logic          gena,
   input  logic          mdu_stb_i,
   input  logic          mdu_kill_i,
   input  logic [2:0]    mdu_op_i,
   input  logic [DW-1:0] mdu_opa_i,
   input  logic [DW-1:0] mdu_opb_i,
   output logic [DW-1:0] mdu_res_o,
   output logic          mdu_done_o,
   output logic          mdu_busy_o,
   output logic          mdu_dz_o,
   output logic          mdu_ovf_o
);

   mduState_t       state;
   mduState_t       nextState;
   mduState_t       acceptState;
   logic [2:0]      opReg;
   logic [DW-1:0]   opaReg;
   logic [DW-1:0]   opbReg;
   logic [DW-1:0]   resReg;
   logic [2*DW-1:0] prodReg;
   logic [2*DW-1:0] product;
   logic            prodValid;
   logic            accept;
   logic            isMulOp;
   logic            signA;
   logic            signB;
   logic signed [DW:0] mulA;
   logic signed [DW:0] mulB;

   assign accept  = mdu_stb_i & gena & ~mdu_kill_i & ((state == ST_IDLE) | (state == ST_DONE));
   assign isMulOp = ~opReg[2];
   assign signA   = (opReg == OP_MULH) | (opReg == OP_MULHSU);
   assign signB   = (opReg == OP_MULH);

   // One extra bit per operand lets a single signed multiply cover all sign mixes.
   assign mulA    = {signA & opaReg[DW-1], opaReg};
   assign mulB    = {signB & opbReg[DW-1], opbReg};
   assign product = (2*DW)'(mulA) * (2*DW)'(mulB);

`ifdef AEMB_MDU_DIV_EN
   logic [DW-1:0] magA;
   logic [DW-1:0] magB;
   logic [DW-1:0] quotient;
   logic          isSigned;
   logic          divRunning;
   logic          divLast;
   logic          divStart;
   logic          divDz;
   logic          divOvf;
   logic          divSpecial;
   logic          negQuo;
   logic          dzReg;
   logic          ovfReg;

   assign isSigned    = (opReg == OP_IDIV);
   assign magA        = (isSigned & opaReg[DW-1]) ? -opaReg : opaReg;
   assign magB        = (isSigned & opbReg[DW-1]) ? -opbReg : opbReg;
   assign divDz       = (opaReg == '0);
   assign divOvf      = isSigned & (opbReg == {1'b1, {(DW-1){1'b0}}}) & (&opaReg);
   assign divSpecial  = divDz | divOvf;
   assign negQuo      = isSigned & (opaReg[DW-1] ^ opbReg[DW-1]);
   assign divStart    = (state == ST_DIV) & ~divRunning & ~divSpecial & ~mdu_kill_i;
   assign acceptState = ((mdu_op_i == OP_IDIV) || (mdu_op_i == OP_IDIVU)) ? ST_DIV : ST_MUL;
   assign mdu_dz_o    = dzReg;
   assign mdu_ovf_o   = ovfReg;

   aemb_mdu_div #(.DW(DW)) uDiv (
      .gclk     (gclk),
      .grst     (grst),
      .abort    (mdu_kill_i),
      .start    (divStart),
      .dividend (magB),
      .divisor  (magA),
      .running  (divRunning),
      .last     (divLast),
      .quotient (quotient)
   );

   // Flags resolve in the first DIV cycle, before the divider would start.
   always_ff @(posedge gclk) begin
      if (grst || mdu_kill_i || accept) begin
         dzReg  <= 1'b0;
         ovfReg <= 1'b0;
      end else if ((state == ST_DIV) && !divRunning && divSpecial) begin
         dzReg  <= divDz;
         ovfReg <= ~divDz;
      end
   end
`else
   assign acceptState = ST_MUL;
   assign mdu_dz_o    = 1'b0;
   assign mdu_ovf_o   = 1'b0;
`endif

   // Reserved ops also pass through MUL, spending one cycle there before DONE.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: if (accept) nextState = acceptState;
         ST_MUL:  if (!isMulOp || prodValid) nextState = ST_DONE;
`ifdef AEMB_MDU_DIV_EN
         ST_DIV: begin
            if (!divRunning) begin
               if (divSpecial) nextState = ST_DONE;
            end else if (divLast) begin
               nextState = ST_FIX;
            end
         end
         ST_FIX:  nextState = ST_DONE;
`endif
         ST_DONE: begin
            if (accept) nextState = acceptState;
            else if (gena) nextState = ST_IDLE;
         end
         default: nextState = ST_IDLE;
      endcase
      if (mdu_kill_i) nextState = ST_IDLE;
   end

   always_ff @(posedge gclk) begin
      if (grst) begin
         state     <= ST_IDLE;
         opReg     <= '0;
         opaReg    <= '0;
         opbReg    <= '0;
         prodReg   <= '0;
         prodValid <= 1'b0;
         resReg    <= '0;
      end else begin
         state <= nextState;
         if (accept) begin
            opReg     <= mdu_op_i;
            opaReg    <= mdu_opa_i;
            opbReg    <= mdu_opb_i;
            prodValid <= 1'b0;
         end
         case (state)
            ST_MUL: begin
               if (isMulOp && !prodValid) begin
                  prodReg   <= product;
                  prodValid <= 1'b1;
               end else if (!isMulOp) begin
                  resReg <= '0;
               end else if (opReg == OP_MUL) begin
                  resReg <= prodReg[DW-1:0];
               end else begin
                  resReg <= prodReg[2*DW-1:DW];
               end
            end
`ifdef AEMB_MDU_DIV_EN
            ST_DIV: if (!divRunning && divSpecial) resReg <= divDz ? '0 : opbReg;
            ST_FIX: resReg <= negQuo ? -quotient : quotient;
`endif
            default: ;
         endcase
      end
   end

   assign mdu_res_o  = resReg;
   assign mdu_done_o = (state == ST_DONE);
   assign mdu_busy_o = (state == ST_MUL) | (state == ST_DIV) | (state == ST_FIX);

endmodule

// File: tb/tb_aemb_mdu.sv
// Scoreboard bench for aemb_mdu: stimulus pushes expected results, a monitor
// checks each rising mdu_done_o. Division vectors follow AEMB_MDU_DIV_EN.
module tb_aemb_mdu;

   localparam int DW      = 32;
   localparam int MUL_LAT = 2;
   localparam int SPC_LAT = 1;
   localparam int DIV_LAT = DW + 2;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        dz;
      logic        ovf;
      int          lat;
      int          issueCycle;
   } scoreEntry_t;

   logic          gclk;
   logic          grst;
   logic          gena;
   logic          mdu_stb_i;
   logic          mdu_kill_i;
   logic [2:0]    mdu_op_i;
   logic [DW-1:0] mdu_opa_i;
   logic [DW-1:0] mdu_opb_i;
   logic [DW-1:0] mdu_res_o;
   logic          mdu_done_o;
   logic          mdu_busy_o;
   logic          mdu_dz_o;
   logic          mdu_ovf_o;

   scoreEntry_t expQ[$];
   scoreEntry_t popped;
   int          compared   = 0;
   int          mismatched = 0;
   int          cycleCount = 0;
   int          busyCount  = 0;
   logic        prevDone   = 1'b0;
   bit          sawDone;

   aemb_mdu #(.DW(DW)) dut (
      .gclk       (gclk),
      .grst       (grst),
      .gena       (gena),
      .mdu_stb_i  (mdu_stb_i),
      .mdu_kill_i (mdu_kill_i),
      .mdu_op_i   (mdu_op_i),
      .mdu_opa_i  (mdu_opa_i),
      .mdu_opb_i  (mdu_opb_i),
      .mdu_res_o  (mdu_res_o),
      .mdu_done_o (mdu_done_o),
      .mdu_busy_o (mdu_busy_o),
      .mdu_dz_o   (mdu_dz_o),
      .mdu_ovf_o  (mdu_ovf_o)
   );

   initial begin
      gclk = 1'b0;
      forever #5 gclk = ~gclk;
   end

   always @(posedge gclk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one request at the current negedge; the next posedge is the accepting edge.
   task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input logic dz,
                                input logic ovf, input int lat, input bit track);
      scoreEntry_t e;
      mdu_op_i  = op;
      mdu_opa_i = a;
      mdu_opb_i = b;
      mdu_stb_i = 1'b1;
      gena      = 1'b1;
      @(posedge gclk);
      #1;
      mdu_stb_i = 1'b0;
      if (track) begin
         e.name       = name;
         e.res        = res;
         e.dz         = dz;
         e.ovf        = ovf;
         e.lat        = lat;
         e.issueCycle = cycleCount;
         expQ.push_back(e);
      end
   endtask

   task automatic waitDone(input string name, input int maxCycles);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < maxCycles && !seen; n++) begin
         @(negedge gclk);
         if (mdu_done_o) seen = 1'b1;
      end
      checkOutput({name, ".doneSeen"}, 32'(seen), 32'd1);
   endtask

   // Monitor: busyCount tallies consecutive busy cycles leading into each done.
   initial begin
      forever begin
         @(negedge gclk);
         if (mdu_done_o && !prevDone) begin
            checkOutput("doneHasRequest", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               popped = expQ.pop_front();
               checkOutput({popped.name, ".res"}, mdu_res_o, popped.res);
               checkOutput({popped.name, ".dz"}, 32'(mdu_dz_o), 32'(popped.dz));
               checkOutput({popped.name, ".ovf"}, 32'(mdu_ovf_o), 32'(popped.ovf));
               checkOutput({popped.name, ".latency"}, 32'(cycleCount - popped.issueCycle), 32'(popped.lat));
               checkOutput({popped.name, ".busyCycles"}, 32'(busyCount + int'(mdu_busy_o)), 32'(popped.lat));
            end
         end
         prevDone  = mdu_done_o;
         busyCount = mdu_busy_o ? busyCount + 1 : 0;
      end
   end

   task automatic checkAllZero(input string name);
      checkOutput({name, ".res"}, mdu_res_o, 32'd0);
      checkOutput({name, ".done"}, 32'(mdu_done_o), 32'd0);
      checkOutput({name, ".busy"}, 32'(mdu_busy_o), 32'd0);
      checkOutput({name, ".dz"}, 32'(mdu_dz_o), 32'd0);
      checkOutput({name, ".ovf"}, 32'(mdu_ovf_o), 32'd0);
   endtask

   initial begin
      logic [2:0] abortOp;
      int         abortDelay;
`ifdef AEMB_MDU_DIV_EN
      abortOp    = 3'd4;
      abortDelay = 12;
`else
      abortOp    = 3'd0;
      abortDelay = 1;
`endif
      grst       = 1'b1;
      gena       = 1'b1;
      mdu_stb_i  = 1'b0;
      mdu_kill_i = 1'b0;
      mdu_op_i   = 3'd0;
      mdu_opa_i  = '0;
      mdu_opb_i  = '0;
      repeat (3) @(negedge gclk);
      checkAllZero("reset");
      grst = 1'b0;
      @(negedge gclk);

      applyStimulus("mul",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mul", 10);
      applyStimulus("mulh",    3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulh", 10);
      applyStimulus("mulhu",   3'd2, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulhu", 10);
      applyStimulus("mulhsuP", 3'd3, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulhsuP", 10);
      applyStimulus("mulhsuN", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulhsuN", 10);
      applyStimulus("mulhMin", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulhMin", 10);
      applyStimulus("mulMin",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("mulMin", 10);
      applyStimulus("rsvd7",   3'd7, 32'd5, 32'd9, 32'd0, 1'b0, 1'b0, SPC_LAT, 1'b1);
      waitDone("rsvd7", 10);

`ifdef AEMB_MDU_DIV_EN
      applyStimulus("idivNeg",  3'd4, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b0, 1'b0, DIV_LAT, 1'b1);
      waitDone("idivNeg", 60);
      applyStimulus("idivu",    3'd5, 32'd7, 32'd100, 32'd14, 1'b0, 1'b0, DIV_LAT, 1'b1);
      waitDone("idivu", 60);
      applyStimulus("idivNegA", 3'd4, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFF2, 1'b0, 1'b0, DIV_LAT, 1'b1);
      waitDone("idivNegA", 60);
      applyStimulus("idivuMax", 3'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, DIV_LAT, 1'b1);
      waitDone("idivuMax", 60);
      applyStimulus("idivuBig", 3'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, DIV_LAT, 1'b1);
      waitDone("idivuBig", 60);
      applyStimulus("idivDz",   3'd4, 32'd0, 32'd55, 32'd0, 1'b1, 1'b0, SPC_LAT, 1'b1);
      waitDone("idivDz", 10);
      applyStimulus("idivuDz",  3'd5, 32'd0, 32'd55, 32'd0, 1'b1, 1'b0, SPC_LAT, 1'b1);
      waitDone("idivuDz", 10);
      applyStimulus("idivOvf",  3'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, SPC_LAT, 1'b1);
      waitDone("idivOvf", 10);
`else
      applyStimulus("op4Rsvd",  3'd4, 32'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, SPC_LAT, 1'b1);
      waitDone("op4Rsvd", 10);
      applyStimulus("op5Rsvd",  3'd5, 32'd7, 32'd100, 32'd0, 1'b0, 1'b0, SPC_LAT, 1'b1);
      waitDone("op5Rsvd", 10);
`endif

      // Hold the result with gena low, then accept back-to-back out of DONE.
      applyStimulus("holdMul", 3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0, 1'b0, MUL_LAT, 1'b1);
      gena = 1'b0;
      waitDone("holdMul", 10);
      for (int i = 0; i < 3; i++) begin
         @(negedge gclk);
         checkOutput("hold.done", 32'(mdu_done_o), 32'd1);
         checkOutput("hold.res", mdu_res_o, 32'h2345_6780);
      end
      applyStimulus("b2bMulhu", 3'd2, 32'h1234_5678, 32'h10, 32'h0000_0001, 1'b0, 1'b0, MUL_LAT, 1'b1);
      checkOutput("b2b.doneLow", 32'(mdu_done_o), 32'd0);
      waitDone("b2bMulhu", 10);

      // Kill beats a simultaneous strobe.
      @(negedge gclk);
      mdu_op_i   = 3'd0;
      mdu_stb_i  = 1'b1;
      mdu_kill_i = 1'b1;
      @(posedge gclk);
      #1;
      mdu_stb_i  = 1'b0;
      mdu_kill_i = 1'b0;
      @(negedge gclk);
      checkOutput("killPriority.busy", 32'(mdu_busy_o), 32'd0);

      // Abort an operation in flight; it must never report done.
      applyStimulus("killed", abortOp, 32'd3, 32'd1000, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      repeat (abortDelay) @(negedge gclk);
      mdu_kill_i = 1'b1;
      @(posedge gclk);
      #1;
      mdu_kill_i = 1'b0;
      checkOutput("kill.busy", 32'(mdu_busy_o), 32'd0);
      checkOutput("kill.done", 32'(mdu_done_o), 32'd0);
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge gclk);
         if (mdu_done_o) sawDone = 1'b1;
      end
      checkOutput("kill.noDone", 32'(sawDone), 32'd0);
      applyStimulus("afterKill", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("afterKill", 10);

      // Same abort via reset: every output returns to zero.
      applyStimulus("resetMid", abortOp, 32'd3, 32'd1000, 32'd0, 1'b0, 1'b0, 0, 1'b0);
      repeat (abortDelay) @(negedge gclk);
      grst = 1'b1;
      @(posedge gclk);
      #1;
      checkAllZero("resetMid");
      grst = 1'b0;
      @(negedge gclk);
      applyStimulus("afterReset", 3'd0, 32'd9, 32'd9, 32'd81, 1'b0, 1'b0, MUL_LAT, 1'b1);
      waitDone("afterReset", 10);

      repeat (3) @(negedge gclk);
      checkOutput("pendingAtEnd", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aemb_mdu.md
# aemb_mdu

Parametrised multi-cycle multiply/divide unit for the AEMB execute stage, succeeding the fixed-width single-cycle multiplier option of the main execution ALU. It accepts one operation per handshake and computes the low or high word of a full-width product, or a signed/unsigned iterative quotient. While an operation is in progress it raises a stall request to the pipeline. The execute-stage result mux selects `mdu_res_o` when `mdu_done_o` is high.

## Interface
- `DW`, 32: operand and result width; even, at least 8.
- `gclk` in 1: clock.
- `grst` in 1: reset, synchronous, active-high.
- `gena` in 1: pipeline advance; gates acceptance and result consumption only.
- `mdu_stb_i` in 1: operation request.
- `mdu_kill_i` in 1: abort the current operation (branch skip or exception).
- `mdu_op_i` in 3: operation select.
  - 0: MUL, low word.
  - 1: MULH, signed×signed high word.
  - 2: MULHU, unsigned high word.
  - 3: MULHSU, signed opa × unsigned opb, high word.
  - 4: IDIV, signed.
  - 5: IDIVU, unsigned.
  - 6–7: reserved.
- `mdu_opa_i` in DW: multiplicand / divisor.
- `mdu_opb_i` in DW: multiplier / dividend.
- `mdu_res_o` out DW: result. Reset value 0.
- `mdu_done_o` out 1: result valid. Reset value 0.
- `mdu_busy_o` out 1: stall request. Reset value 0.
- `mdu_dz_o` out 1: divide-by-zero flag, valid with done. Reset value 0.
- `mdu_ovf_o` out 1: signed divide overflow flag, valid with done. Reset value 0.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- Acceptance happens on a clock edge when `mdu_stb_i & gena & !mdu_kill_i` and the state is IDLE or DONE. Operands and op are registered at that edge.
- MUL path:
  - In state MUL the full 2·DW product is registered with the sign treatment set by the op.
  - Then go to DONE.
  - Result is product[DW-1:0] for MUL, product[2DW-1:DW] for the high-word ops.
- DIV path: quotient = opb / opa, truncated toward zero. The remainder is discarded.
  - Divisor zero: go straight to DONE with result 0 and `mdu_dz_o` = 1.
  - IDIV with opb = 2^(DW-1) and opa = all-ones: go straight to DONE with result = opb and `mdu_ovf_o` = 1.
  - Otherwise: register the magnitudes, then run DW restoring iterations in DIV under a counter 0..DW-1. Go to FIX, which negates the quotient when the operand signs differ (IDIV only), then DONE.
- Reserved ops go straight to DONE with result 0 and both flags 0.
- DONE:
  - Result and flags are held stable.
  - On the first edge with `gena` = 1, return to IDLE, or accept a new request back-to-back.
  - `mdu_done_o` = 1 only in DONE.
- `mdu_busy_o` = 1 in MUL, DIV and FIX.
- `mdu_kill_i` in any state forces IDLE at the next edge, and clears done and both flags. Kill takes priority over a simultaneous strobe.
- `grst` takes priority over everything: IDLE, all outputs 0, counter 0, even mid-division.
- The counter and datapath advance every clock regardless of `gena`.

## Timing
- Latency is counted from the accepting edge E.
- MUL family: DONE after E+2, so `mdu_done_o` is high in the cycle following edge E+2.
- IDIV/IDIVU normal case: DONE after E+DW+2 (1 capture edge, DW iteration edges, 1 FIX edge).
- Divide-by-zero, overflow and reserved ops: DONE after E+1.
- `mdu_busy_o` rises in the cycle after E and falls in the same cycle `mdu_done_o` rises.
- Back-to-back: a strobe accepted in DONE makes `mdu_done_o` low in the following cycle.

## Configuration
- `AEMB_MDU_DIV_EN` defined: IDIV/IDIVU and the DIV/FIX states and divider datapath are present.
- Macro undefined:
  - Ops 4/5 behave as reserved: DONE after E+1, result 0, flags 0.
  - No divider logic or counter is built.
  - `mdu_dz_o` and `mdu_ovf_o` are tied 0.

## Structure
- Package `aemb_mdu_pkg`: op-code constants, state enumeration, counter width function clog2(DW).
- Sub-module `aemb_mdu_div`: restoring divider core with start, magnitude operands, DW-cycle iteration and quotient out. It is instantiated only under `AEMB_MDU_DIV_EN`.
- The top level holds the FSM, multiplier, sign fix and handshake.

## Test plan
- MUL, DW=32, opa=7, opb=-3 (0xFFFFFFFD): done after E+2 with result 0xFFFFFFEB. MULH on the same operands gives 0xFFFFFFFF; MULHU gives 0x00000006.
- IDIV, opb=-7, opa=2: busy for 34 cycles, then result 0xFFFFFFFD, dz=0, ovf=0. IDIVU opb=100, opa=7 gives 14.
- IDIV with opa=0: done after E+1, result 0, dz=1.
- IDIV with opb=0x80000000, opa=0xFFFFFFFF: done after E+1, result 0x80000000, ovf=1.
- Division started, then `mdu_kill_i` asserted at iteration 10: IDLE next edge, done never asserts, a new MUL is accepted normally. Repeat with `grst` instead: all outputs 0.
- Done held for 3 cycles with `gena` = 0: result stays stable. A new strobe arriving with `gena` = 1 is accepted back-to-back. With the macro undefined, op 4 returns 0 after E+1.
